xor_frame_stats: RTL
====================

Name: xor_frame_stats

Overview:
- Downstream consumer of the registered XOR bit produced by the alwaysclock stage.
- Collects a serial bit stream into fixed-length frames, then reports three values per frame: parity, ones-count and transition count.
- Uses valid/ready handshakes on both input and output, so it can sit between the XOR stage and any stalling sink.

Parameters:
- FRAME_LEN, 8, bits per frame; must be >= 2; elaboration error otherwise.
- CNT_W, $clog2(FRAME_LEN+1), derived localparam; width of the count outputs; not overridable.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bit_in  input  1  serial data bit (XOR result); ignored when bit_valid=0.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  block can accept a bit this cycle.
- out_valid  output  1  frame result is available.
- out_ready  input  1  sink accepts the frame result.
- out_parity  output  1  XOR of all bits in the frame.
- out_ones  output  CNT_W  number of 1 bits in the frame (0..FRAME_LEN).
- out_edges  output  CNT_W  number of adjacent-bit changes within the frame (0..FRAME_LEN-1).

Behaviour:
- Clock and reset:
  - One clock (clk); reset rst_n is asynchronous, active-low.
  - Reset asserted forces immediately: state=IDLE, bit_ready=1, out_valid=0, out_parity=0, out_ones=0, out_edges=0, internal idx/acc/prev=0.
  - Release is taken synchronously at the next clk edge.
- Handshakes:
  - Input accept = bit_valid && bit_ready at a rising edge.
  - Output transfer = out_valid && out_ready at a rising edge.
- All outputs are registered; no combinational path from out_ready or bit_valid to any output.
- States: IDLE, ACCUM, HOLD. bit_ready = (state != HOLD).
- IDLE:
  - On accept: idx=1, parity=bit, ones=bit, edges=0, prev=bit; go to ACCUM.
  - No accept: stay in IDLE.
- ACCUM:
  - On accept: parity^=bit; ones+=bit; edges+=(bit!=prev); prev=bit; idx+=1.
  - Cycles with bit_valid=0 are bubbles: no state change, not counted.
  - When the accepted bit is the FRAME_LEN-th (idx==FRAME_LEN-1 before the update):
    - copy final parity/ones/edges into the out_* registers;
    - set out_valid=1 on that same edge, so results are visible the cycle after the last accept;
    - go to HOLD.
- HOLD:
  - bit_ready=0; out_* held stable while out_valid && !out_ready.
  - On output transfer: out_valid=0, go to IDLE; bit_ready=1 from the next cycle.
  - out_* keep their last values after transfer; they are only meaningful while out_valid=1.
- Throughput: at most one frame per FRAME_LEN+1 cycles (one bubble for the HOLD handshake when out_ready=1).
- Boundaries:
  - prev does not carry across frames, so the first bit of a frame never counts as an edge.
  - out_ones can reach FRAME_LEN and out_edges FRAME_LEN-1; CNT_W holds both without wrap.
  - idx wraps to 0 only through the HOLD→IDLE path.
- Reset mid-frame or mid-HOLD: the partial or pending frame is discarded with no output.
- bit_in is X-tolerant when bit_valid=0: it never enters the accumulator.

Decomposition:
- Shared package xor_stream_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_HOLD=2'd2;
  - default FRAME_LEN constant, used by both the XOR stage bench and this block.
- One natural sub-module: frame_stats.
  - Datapath accumulator for parity/ones/edges/prev, with clear and enable inputs driven by the FSM.
  - The top level keeps the FSM, handshakes and output registers.

Test Plan (FRAME_LEN=8):
- Reset: rst_n=0 mid-clock → immediately bit_ready=1, out_valid=0, out_parity=0, out_ones=0, out_edges=0.
- Contiguous frame 1,0,1,1,0,0,0,1 with out_ready=1:
  - out_valid=1 exactly one cycle after the 8th accept;
  - parity=0, ones=4, edges=4;
  - bit_ready back to 1 one cycle after the transfer.
- Frame of eight 1s with bit_valid low on alternate cycles → parity=0, ones=8, edges=0; bubbles not counted.
- Frame 1,1,1,1,1,1,1,0, then out_ready=0 for 5 cycles with bit_valid=1, bit_in=1:
  - result parity=1, ones=7, edges=1;
  - bit_ready=0 and outputs stable for all 5 cycles; no bits consumed;
  - after out_ready=1 the next frame starts fresh.
- Reset after 3 bits (1,1,0) of a frame, then frame 0,1,0,1,0,1,0,1 → only one result: parity=0, ones=4, edges=7.
- Two back-to-back frames (00000000, then 10000000) across the HOLD bubble:
  - results (0,0,0) then (1,1,1);
  - the first bit of frame 2 does not create a cross-frame edge.

Source files
------------

// File: rtl/xor_stream_pkg.sv
// Shared definitions for the XOR bit stream: the default frame length and the
// state encoding of the frame statistics FSM.
package xor_stream_pkg;

   localparam int DEFAULT_FRAME_LEN = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/xor_frame_stats_if.sv
// Bit-in / frame-result handshake bundle for xor_frame_stats.
// The master is the environment; the slave is the statistics block.
interface xor_frame_stats_if
   import xor_stream_pkg::*;
#(
   parameter int FRAME_LEN = DEFAULT_FRAME_LEN
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);

   logic             bit_in;
   logic             bit_valid;
   logic             bit_ready;
   logic             out_valid;
   logic             out_ready;
   logic             out_parity;
   logic [CNT_W-1:0] out_ones;
   logic [CNT_W-1:0] out_edges;

   modport master (
      output bit_in, bit_valid, out_ready,
      input  bit_ready, out_valid, out_parity, out_ones, out_edges
   );

   modport slave (
      input  bit_in, bit_valid, out_ready,
      output bit_ready, out_valid, out_parity, out_ones, out_edges
   );

endinterface

// File: rtl/xor_frame_stats_frame_stats.sv
// Per-frame accumulator for parity, ones-count and transition count.
// clear (qualified by en) starts a new frame with the current bit.
module frame_stats #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic             bit_in,
   output logic             nxt_parity,
   output logic [CNT_W-1:0] nxt_ones,
   output logic [CNT_W-1:0] nxt_edges
);

   logic             parity;
   logic             prev;
   logic [CNT_W-1:0] ones;
   logic [CNT_W-1:0] edges;

   // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
   always_comb begin
      nxt_parity = parity ^ bit_in;
      nxt_ones   = ones + CNT_W'(bit_in);
      nxt_edges  = edges + CNT_W'(bit_in != prev);
      if (clear) begin
         // First bit of a frame has no predecessor, so it never counts as an edge.
         nxt_parity = bit_in;
         nxt_ones   = CNT_W'(bit_in);
         nxt_edges  = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity <= 1'b0;
         prev   <= 1'b0;
         ones   <= '0;
         edges  <= '0;
      end else if (en) begin
         parity <= nxt_parity;
         prev   <= bit_in;
         ones   <= nxt_ones;
         edges  <= nxt_edges;
      end
   end

endmodule

// File: rtl/xor_frame_stats.sv
// Frames a serial XOR bit stream and reports parity, ones and edge counts per
// frame over a registered valid/ready output.
module xor_frame_stats
   import xor_stream_pkg::*;
#(
   parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
   input logic            clk,
   input logic            rst_n,
   xor_frame_stats_if.slave bus
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam int IDX_W = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   if (FRAME_LEN < 2) begin : g_bad_frame_len
      $error("xor_frame_stats: FRAME_LEN must be >= 2");
   end

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             bit_ready_q;
   logic             out_valid_q, out_valid_nxt;
   logic             out_parity_q;
   logic [CNT_W-1:0] out_ones_q;
   logic [CNT_W-1:0] out_edges_q;

   logic             accept;
   logic             xfer;
   logic             acc_en;
   logic             acc_clear;
   logic             load_out;
   logic             nxt_parity;
   logic [CNT_W-1:0] nxt_ones;
   logic [CNT_W-1:0] nxt_edges;

   assign accept = bus.bit_valid && bit_ready_q;
   assign xfer   = out_valid_q && bus.out_ready;

   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      out_valid_nxt = out_valid_q;
      acc_en        = 1'b0;
      acc_clear     = 1'b0;
      load_out      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               acc_en    = 1'b1;
               acc_clear = 1'b1;
               idx_nxt   = IDX_W'(1);
               state_nxt = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (accept) begin
               acc_en = 1'b1;
               if (idx == LAST_IDX) begin
                  // Results land in the output registers on the same edge as the last bit.
                  load_out      = 1'b1;
                  out_valid_nxt = 1'b1;
                  state_nxt     = ST_HOLD;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         ST_HOLD: begin
            if (xfer) begin
               out_valid_nxt = 1'b0;
               idx_nxt       = '0;
               state_nxt     = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         idx          <= '0;
         bit_ready_q  <= 1'b1;
         out_valid_q  <= 1'b0;
         out_parity_q <= 1'b0;
         out_ones_q   <= '0;
         out_edges_q  <= '0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         bit_ready_q <= (state_nxt != ST_HOLD);
         out_valid_q <= out_valid_nxt;
         if (load_out) begin
            out_parity_q <= nxt_parity;
            out_ones_q   <= nxt_ones;
            out_edges_q  <= nxt_edges;
         end
      end
   end

   frame_stats #(
      .CNT_W (CNT_W)
   ) u_frame_stats (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (acc_clear),
      .en         (acc_en),
      .bit_in     (bus.bit_in),
      .nxt_parity (nxt_parity),
      .nxt_ones   (nxt_ones),
      .nxt_edges  (nxt_edges)
   );

   assign bus.bit_ready  = bit_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_parity = out_parity_q;
   assign bus.out_ones   = out_ones_q;
   assign bus.out_edges  = out_edges_q;

endmodule
